// File: rtl/jtag_bscan_tap.sv
// ----------------------------------------------------------------------------
// jtag_bscan_tap
//
// 1149.1-style TAP controller with a boundary-scan register sitting between
// the chip pins and a core block. It has a configurable instruction register,
// a 32-bit IDCODE register, a 1-bit bypass register, and update latches that
// feed the EXTEST / INTEST / CLAMP pin and core muxing.
//
// Ports
//   TCK        in   test clock, used on both edges (rise: FSM/shift, fall: update/TDO)
//   TRST       in   asynchronous active-high reset of the whole block
//   TMS        in   test mode select, sampled on TCK rise
//   TDI        in   serial data in, sampled on TCK rise
//   TDO        out  serial data out, registered on TCK fall
//   inputs     in   [NUM_INPUTS]  pin values heading into the core
//   to_core    out  [NUM_INPUTS]  values actually presented to the core
//   from_core  in   [NUM_OUTPUTS] core results heading to the pins
//   outputs    out  [NUM_OUTPUTS] values actually driven to the pins
// ----------------------------------------------------------------------------
module jtag_bscan_tap #(
    parameter int          NUM_INPUTS  = 41,
    parameter int          NUM_OUTPUTS = 24,
    parameter int          IR_WIDTH    = 4,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
    input  logic                   TCK,
    input  logic                   TRST,
    input  logic                   TMS,
    input  logic                   TDI,
    output logic                   TDO,
    input  logic [NUM_INPUTS-1:0]  inputs,
    output logic [NUM_INPUTS-1:0]  to_core,
    input  logic [NUM_OUTPUTS-1:0] from_core,
    output logic [NUM_OUTPUTS-1:0] outputs
);

    localparam int NB = NUM_INPUTS + NUM_OUTPUTS;

    // Instruction encodings; every code not listed (including all ones)
    // selects the bypass register.
    localparam logic [IR_WIDTH-1:0] IR_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_INTEST = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] IR_CLAMP  = IR_WIDTH'(4);

    typedef enum logic [3:0] {
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_SH_DR,
        ST_EX1_DR,
        ST_PAU_DR,
        ST_EX2_DR,
        ST_UPD_DR,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_SH_IR,
        ST_EX1_IR,
        ST_PAU_IR,
        ST_EX2_IR,
        ST_UPD_IR
    } tap_state_t;

    tap_state_t r_state;
    tap_state_t w_state_next;

    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] w_ir_eff;
    logic [31:0]         r_id;
    logic                r_bypass;
    logic [NB-1:0]       r_bsr;
    logic [NB-1:0]       r_upd;
    logic [NB-1:0]       w_bsr_cap;
    logic [NB-1:0]       w_bsr_next;
    logic                r_tdo;

    logic w_sel_bsr;
    logic w_sel_id;
    logic w_drive_out;
    logic w_drive_in;
    logic w_bsr_capture;
    logic w_bsr_shift;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_TLR:    w_state_next = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    w_state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_state_next = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: w_state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_state_next = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: w_state_next = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: w_state_next = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: w_state_next = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: w_state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_state_next = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: w_state_next = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: w_state_next = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_state_next = TMS ? ST_SEL_DR : ST_RTI;
            default:   w_state_next = ST_TLR;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_shift <= '0;
        end else if (r_state == ST_CAP_IR) begin
            r_ir_shift <= IR_WIDTH'(1);
        end else if (r_state == ST_SH_IR) begin
            r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir <= IR_IDCODE;
        end else if (r_state == ST_TLR) begin
            r_ir <= IR_IDCODE;
        end else if (r_state == ST_UPD_IR) begin
            r_ir <= r_ir_shift;
        end
    end

    // The stored IR only follows Test-Logic-Reset on the next fall, but the
    // block must look like IDCODE from the rise that enters the state, so the
    // state overrides the register here.
    assign w_ir_eff = (r_state == ST_TLR) ? IR_IDCODE : r_ir;

    always_comb begin
        w_sel_bsr   = 1'b0;
        w_sel_id    = 1'b0;
        w_drive_out = 1'b0;
        w_drive_in  = 1'b0;
        case (w_ir_eff)
            IR_EXTEST: begin
                w_sel_bsr   = 1'b1;
                w_drive_out = 1'b1;
            end
            IR_SAMPLE: begin
                w_sel_bsr   = 1'b1;
            end
            IR_IDCODE: begin
                w_sel_id    = 1'b1;
            end
            IR_INTEST: begin
                w_sel_bsr   = 1'b1;
                w_drive_out = 1'b1;
                w_drive_in  = 1'b1;
            end
            IR_CLAMP: begin
                w_drive_out = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    assign w_bsr_capture = (r_state == ST_CAP_DR) && w_sel_bsr;
    assign w_bsr_shift   = (r_state == ST_SH_DR) && w_sel_bsr;
    assign w_bsr_cap     = {inputs, from_core};

    // Boundary cells: cell NB-1 takes TDI, every other cell takes its upper
    // neighbour, so the chain shifts right toward output cell 0.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bsr_cell
            logic w_sin;
            if (gi == NB - 1) begin : g_head
                assign w_sin = TDI;
            end else begin : g_body
                assign w_sin = r_bsr[gi+1];
            end
            assign w_bsr_next[gi] = w_bsr_capture ? w_bsr_cap[gi] :
                                    w_bsr_shift   ? w_sin         :
                                                    r_bsr[gi];
        end
    endgenerate

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bsr <= '0;
        end else begin
            r_bsr <= w_bsr_next;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_id <= '0;
        end else if (r_state == ST_CAP_DR && w_sel_id) begin
            r_id <= IDCODE_VAL;
        end else if (r_state == ST_SH_DR && w_sel_id) begin
            r_id <= {TDI, r_id[31:1]};
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_CAP_DR && !w_sel_bsr && !w_sel_id) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_SH_DR && !w_sel_bsr && !w_sel_id) begin
            r_bypass <= TDI;
        end
    end

    // Update latches only load while the boundary register is the selected
    // DR; switching the IR leaves whatever was last preloaded in place.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            r_upd <= '0;
        end else if (r_state == ST_UPD_DR && w_sel_bsr) begin
            r_upd <= r_bsr;
        end
    end

    // ------------------------------------------------------------------
    // TDO, registered on the fall
    // ------------------------------------------------------------------
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            r_tdo <= 1'b0;
        end else if (r_state == ST_SH_DR) begin
            r_tdo <= w_sel_bsr ? r_bsr[0] : (w_sel_id ? r_id[0] : r_bypass);
        end else if (r_state == ST_SH_IR) begin
            r_tdo <= r_ir_shift[0];
        end else begin
            r_tdo <= 1'b0;
        end
    end

    assign TDO = r_tdo;

    // ------------------------------------------------------------------
    // Pin / core muxing
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out_mux
            assign outputs[gi] = w_drive_out ? r_upd[gi] : from_core[gi];
        end
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in_mux
            assign to_core[gi] = w_drive_in ? r_upd[NUM_OUTPUTS+gi] : inputs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_jtag_bscan_tap.sv
module tb_jtag_bscan_tap;

    localparam int          NI  = 41;
    localparam int          NO  = 24;
    localparam int          IRW = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;

    logic          TCK = 1'b0;
    logic          TRST;
    logic          TMS;
    logic          TDI;
    logic          TDO;
    logic [NI-1:0] inputs;
    logic [NI-1:0] to_core;
    logic [NO-1:0] from_core;
    logic [NO-1:0] outputs;

    logic [NO-1:0] from_core_drv;
    logic          core_mode;
    logic [NO-1:0] mac_result;

    int total = 0;
    int bad   = 0;

    logic [127:0] sb_exp[$];

    jtag_bscan_tap #(
        .NUM_INPUTS (NI),
        .NUM_OUTPUTS(NO),
        .IR_WIDTH   (IRW),
        .IDCODE_VAL (IDV)
    ) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .inputs   (inputs),
        .to_core  (to_core),
        .from_core(from_core),
        .outputs  (outputs)
    );

    always #5 TCK = ~TCK;

    // Tiny stand-in core: to_core = {.., c[24:17], b[16:9], a[8:1], resetn[0]}
    always_comb begin
        mac_result = '0;
        if (to_core[0])
            mac_result = NO'(to_core[8:1]) * NO'(to_core[16:9]) + NO'(to_core[24:17]);
    end

    always_comb from_core = core_mode ? mac_result : from_core_drv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        bad = bad + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // One TCK: drive TMS/TDI, let the rise and the following fall happen,
    // then sample TDO just after the fall.
    task automatic step(input logic tms, input logic tdi, output logic tdo);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        tdo = TDO;
    endtask

    // Starts from Run-Test/Idle or any Update state, ends in Update-IR.
    task automatic scan_ir(input logic [IRW-1:0] din, output logic [IRW-1:0] dout);
        logic t;
        dout = '0;
        step(1'b1, 1'b0, t);
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        dout[0] = t;
        for (int i = 0; i < IRW; i++) begin
            step(i == IRW - 1, din[i], t);
            if (i < IRW - 1) dout[i+1] = t;
        end
        step(1'b1, 1'b0, t);
        $display("scan_ir in=%h out=%h", din, dout);
    endtask

    // Starts from Run-Test/Idle or any Update state, ends in Update-DR.
    task automatic scan_dr(input int len, input logic [127:0] din, output logic [127:0] dout);
        logic t;
        dout = '0;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        dout[0] = t;
        for (int i = 0; i < len; i++) begin
            step(i == len - 1, din[i], t);
            if (i < len - 1) dout[i+1] = t;
        end
        step(1'b1, 1'b0, t);
        $display("scan_dr len=%0d in=%h out=%h", len, din, dout);
    endtask

    task automatic test_reset();
        TRST = 1'b1;
        TMS = 1'b1;
        TDI = 1'b0;
        core_mode = 1'b0;
        inputs = 41'h0_1357_9BDF_02;
        from_core_drv = 24'h13579B;
        #12;
        total++;
        if (TDO !== 1'b0) begin
            bad++;
            $display("FAIL reset_tdo got=%b exp=0", TDO);
        end
        total++;
        if (to_core !== inputs) begin
            bad++;
            $display("FAIL reset_to_core got=%h exp=%h", to_core, inputs);
        end
        inputs = 41'h1_0F0F_0F0F_0F;
        from_core_drv = 24'hC3C3C3;
        #1;
        total++;
        if (to_core !== 41'h1_0F0F_0F0F_0F) begin
            bad++;
            $display("FAIL reset_to_core_follow got=%h exp=%h", to_core, 41'h1_0F0F_0F0F_0F);
        end
        total++;
        if (outputs !== 24'hC3C3C3) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", outputs, 24'hC3C3C3);
        end
        @(negedge TCK);
        TRST = 1'b0;
        #1;
        $display("reset released");
    endtask

    task automatic test_idcode(input logic [127:0] din);
        logic         t;
        logic [127:0] got;
        logic [127:0] exp;
        step(1'b0, 1'b0, t);
        sb_exp.push_back(128'(IDV));
        scan_dr(32, din, got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL idcode got=%h exp=%h", got[31:0], exp[31:0]);
        end
        total++;
        if (to_core !== inputs || outputs !== from_core) begin
            bad++;
            $display("FAIL idcode_transparent to_core=%h exp=%h outputs=%h exp=%h",
                     to_core, inputs, outputs, from_core);
        end
    endtask

    task automatic test_ir_bypass();
        logic [IRW-1:0] got_ir;
        logic [127:0]   got;
        logic [127:0]   exp;
        sb_exp.push_back(128'(4'b0001));
        scan_ir(4'hF, got_ir);
        exp = sb_exp.pop_front();
        total++;
        if (128'(got_ir) !== exp) begin
            bad++;
            $display("FAIL ir_capture got=%b exp=%b", got_ir, exp[3:0]);
        end
        // TDI 1,0,1,1,0 -> TDO 0 (captured), then TDI delayed by one TCK
        sb_exp.push_back(128'(5'b11010));
        scan_dr(5, 128'(5'b01101), got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL bypass_delay got=%b exp=%b", got[4:0], exp[4:0]);
        end
    endtask

    task automatic test_sample_extest();
        logic [IRW-1:0] got_ir;
        logic [127:0]   got;
        logic [127:0]   exp;
        inputs = 41'h1_2345_6789_AB;
        from_core_drv = 24'hABCDEF;
        scan_ir(4'h1, got_ir);
        sb_exp.push_back(128'({41'h1_2345_6789_AB, 24'hABCDEF}));
        scan_dr(NI + NO, 128'({41'h0, 24'h5A5A5A}), got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL sample_capture got=%h exp=%h", got, exp);
        end
        total++;
        if (outputs !== 24'hABCDEF) begin
            bad++;
            $display("FAIL sample_transparent got=%h exp=%h", outputs, 24'hABCDEF);
        end
        scan_ir(4'h0, got_ir);
        total++;
        if (outputs !== 24'h5A5A5A) begin
            bad++;
            $display("FAIL extest_outputs got=%h exp=%h", outputs, 24'h5A5A5A);
        end
        total++;
        if (to_core !== 41'h1_2345_6789_AB) begin
            bad++;
            $display("FAIL extest_to_core got=%h exp=%h", to_core, 41'h1_2345_6789_AB);
        end
        from_core_drv = 24'h000F00;
        #1;
        total++;
        if (outputs !== 24'h5A5A5A) begin
            bad++;
            $display("FAIL extest_hold got=%h exp=%h", outputs, 24'h5A5A5A);
        end
    endtask

    task automatic test_intest();
        logic [IRW-1:0] got_ir;
        logic [127:0]   got;
        logic [127:0]   exp;
        logic [NI-1:0]  in_pat;
        in_pat = 41'(1) | (41'(3) << 1) | (41'(4) << 9) | (41'(5) << 17);
        scan_ir(4'h1, got_ir);
        scan_dr(NI + NO, 128'({in_pat, 24'h0}), got);
        scan_ir(4'h3, got_ir);
        total++;
        if (to_core !== in_pat) begin
            bad++;
            $display("FAIL intest_to_core got=%h exp=%h", to_core, in_pat);
        end
        core_mode = 1'b1;
        inputs = 41'h0_00AA_5500_33;
        sb_exp.push_back(128'({41'h0_00AA_5500_33, 24'd17}));
        scan_dr(NI + NO, 128'({in_pat, 24'h0}), got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL intest_capture got=%h exp=%h", got, exp);
        end
        total++;
        if (outputs !== 24'h0) begin
            bad++;
            $display("FAIL intest_outputs got=%h exp=%h", outputs, 24'h0);
        end
        core_mode = 1'b0;
    endtask

    task automatic test_clamp();
        logic [IRW-1:0] got_ir;
        logic [127:0]   got;
        logic [127:0]   exp;
        scan_ir(4'h1, got_ir);
        scan_dr(NI + NO, 128'({41'h0, 24'hFFFFFF}), got);
        scan_ir(4'h4, got_ir);
        total++;
        if (outputs !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL clamp_outputs got=%h exp=%h", outputs, 24'hFFFFFF);
        end
        from_core_drv = 24'h123456;
        sb_exp.push_back(128'(3'b110));
        scan_dr(3, 128'(3'b011), got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL clamp_bypass got=%b exp=%b", got[2:0], exp[2:0]);
        end
        total++;
        if (outputs !== 24'hFFFFFF || to_core !== inputs) begin
            bad++;
            $display("FAIL clamp_hold outputs=%h exp=%h to_core=%h exp=%h",
                     outputs, 24'hFFFFFF, to_core, inputs);
        end
    endtask

    task automatic test_undefined();
        logic [IRW-1:0] got_ir;
        logic [127:0]   got;
        logic [127:0]   exp;
        scan_ir(4'h5, got_ir);
        sb_exp.push_back(128'(3'b010));
        scan_dr(3, 128'(3'b101), got);
        exp = sb_exp.pop_front();
        total++;
        if (got !== exp || outputs !== 24'h123456) begin
            bad++;
            $display("FAIL undefined_bypass got=%b exp=%b outputs=%h exp=%h",
                     got[2:0], exp[2:0], outputs, 24'h123456);
        end
    endtask

    task automatic test_trst_mid_shift();
        logic [IRW-1:0] got_ir;
        logic           t;
        scan_ir(4'h0, got_ir);
        total++;
        if (outputs !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL trst_pre_outputs got=%h exp=%h", outputs, 24'hFFFFFF);
        end
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, t);
        #2;
        TRST = 1'b1;
        #1;
        total++;
        if (TDO !== 1'b0 || outputs !== from_core || to_core !== inputs) begin
            bad++;
            $display("FAIL trst_async tdo=%b outputs=%h exp=%h to_core=%h exp=%h",
                     TDO, outputs, from_core, to_core, inputs);
        end
        @(negedge TCK);
        TRST = 1'b0;
        #1;
        test_idcode(128'h0);
        // update latches were cleared by TRST
        scan_ir(4'h0, got_ir);
        total++;
        if (outputs !== 24'h0) begin
            bad++;
            $display("FAIL trst_latches got=%h exp=%h", outputs, 24'h0);
        end
    endtask

    task automatic test_tms_reset();
        logic t;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, t);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
        total++;
        if (outputs !== from_core || TDO !== 1'b0) begin
            bad++;
            $display("FAIL tms_reset outputs=%h exp=%h tdo=%b exp=0", outputs, from_core, TDO);
        end
    endtask

    task automatic test_back_to_back();
        test_idcode(128'hDEAD_BEEF);
        test_idcode(128'h0);
    endtask

    initial begin
        test_reset();
        test_idcode(128'h0);
        test_ir_bypass();
        test_sample_extest();
        test_intest();
        test_clamp();
        test_undefined();
        test_trst_mid_shift();
        test_tms_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
